ekf_stage_seq: RTL and testbench
================================

Name: ekf_stage_seq

Overview:
- Sequences one EKF-SLAM step on the RSA/NonLinear datapath: PREDICT first, then one NEWLM or UPDATE stage per observation.
- Drives the datapath's stage_val, landmark_num and l_k inputs, and consumes its stage_rdy completion pulses.
- Owns the landmark count and rejects invalid or overflowing observations.
- Sits between the host/PS command path and the datapath top inside the SLAM subsystem.

Parameters:
- LM_W, 10, width of landmark_num and l_k.
- MAX_LM, 1023, maximum number of map landmarks.
- TO_W, 16, width of the stage watchdog counter.
- TIMEOUT, 50000, cycles allowed per stage before abort.

Ports:
- clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- step_val  in  1  host requests one EKF step.
- step_rdy  out  1  high in IDLE; a step starts when step_val && step_rdy.
- obs_val  in  1  observation valid.
- obs_rdy  out  1  observation accepted when obs_val && obs_rdy.
- obs_lk  in  LM_W  landmark index of the observation; ignored when obs_new=1.
- obs_new  in  1  observation is a new landmark.
- obs_last  in  1  final observation of this step.
- lm_clear  in  1  clears the map count; honoured only in IDLE.
- stage_val  out  3  to datapath: 001 PREDICT, 010 NEWLM, 100 UPDATE, 000 none.
- stage_rdy  in  3  from datapath: one-cycle completion pulse, bit matches stage.
- landmark_num  out  LM_W  current map landmark count.
- l_k  out  LM_W  landmark index of the active stage.
- busy  out  1  not in IDLE.
- err_inval  out  1  sticky: observation index >= landmark_num.
- err_full  out  1  sticky: new landmark while landmark_num == MAX_LM.
- err_timeout  out  1  sticky: stage watchdog expired.

Behaviour:
- Reset values: all outputs 0 except step_rdy=1; state IDLE. Reset mid-stage drops stage_val to 0 immediately, asynchronously.
- Stage handshake: stage_val is registered, one-hot, and held constant until the matching stage_rdy bit is sampled high, then returns to 000 the next cycle. Non-matching stage_rdy bits are ignored. l_k and landmark_num are stable throughout the stage.
- IDLE:
  - step_rdy=1.
  - lm_clear sets landmark_num=0; lm_clear takes priority over step_val in the same cycle.
  - Errors are cleared when step_val is accepted.
  - step_val → PRED.
- PRED: stage_val=001. On stage_rdy[0] → OBS.
- OBS: obs_rdy=1, held for exactly the OBS cycles. On accept, latch obs_new, obs_lk, obs_last and go to CHECK.
- CHECK: one cycle, obs_rdy=0.
  - Known observation with obs_lk < landmark_num: l_k=obs_lk → UPD.
  - Known observation with obs_lk >= landmark_num: set err_inval, skip.
  - New observation with landmark_num < MAX_LM: l_k=landmark_num → NEW.
  - New observation with landmark_num == MAX_LM: set err_full, skip.
  - Skip: go to IDLE if obs_last, else OBS.
- NEW: stage_val=010. On stage_rdy[1], landmark_num += 1, then IDLE if obs_last else OBS.
- UPD: stage_val=100. On stage_rdy[2], IDLE if obs_last else OBS.
- Step with zero observations: the host sends no observation. Instead, a step_val pulse seen while in OBS with no obs_val ends the step and returns to IDLE; that step_val is not accepted as a new step.
- Watchdog:
  - Counter cleared on each stage entry, counts while stage_val != 0.
  - On reaching TIMEOUT-1: set err_timeout, stage_val=0, → IDLE. landmark_num is not incremented.
  - A stage_rdy pulse in the same cycle as the timeout wins (normal completion).
- Latency: stage_val asserts 1 cycle after the step_val handshake; the next stage asserts 2 cycles after stage_rdy (OBS accept + CHECK) when obs_val is already high.
- landmark_num saturates at MAX_LM and never wraps.

Decomposition:
- Shared package ekf_pkg: stage encodings STG_NONE/PRED/NEWLM/UPD and the FSM state enum (IDLE, PRED, OBS, CHECK, NEW, UPD).
- Watchdog is a natural sub-module: stage_watchdog (clear, enable, expired; TO_W/TIMEOUT params).

Test Plan:
- Reset, then step_val; stage_rdy=001 after 10 cycles; one known observation obs_lk=0, landmark_num preset to 2 via prior NEWLMs, obs_last → stage_val 001 then 100 with l_k=0; back to IDLE, step_rdy=1.
- From landmark_num=0: step with 3 new observations, last flagged → NEWLM issued with l_k=0,1,2; landmark_num ends at 3; no errors.
- landmark_num=3, known obs_lk=5 with obs_last → err_inval=1, no UPDATE issued, IDLE; next step_val clears err_inval.
- MAX_LM=4, landmark_num=4, new observation → err_full=1, landmark_num stays 4, no NEWLM.
- TIMEOUT=20, stage_rdy never pulses in PRED → stage_val=000 at cycle 20, err_timeout=1, IDLE; stage_rdy=100 during PRED is ignored.
- Assert sys_rst during UPD → stage_val=0 and busy=0 without waiting for a clock edge; landmark_num=0; lm_clear in IDLE zeroes landmark_num; lm_clear during NEW has no effect.

Source files
------------

// File: rtl/ekf_pkg.sv
// Shared encodings for the EKF-SLAM stage sequencer: datapath stage codes
// and the sequencer FSM state set.
package ekf_pkg;

   localparam logic [2:0] STG_NONE  = 3'b000;
   localparam logic [2:0] STG_PRED  = 3'b001;
   localparam logic [2:0] STG_NEWLM = 3'b010;
   localparam logic [2:0] STG_UPD   = 3'b100;

   typedef enum logic [2:0] {
      IDLE,
      PRED,
      OBS,
      CHECK,
      NEW,
      UPD
   } state_t;

   // Datapath stage code presented while the FSM sits in a given state.
   function automatic logic [2:0] stage_of(input state_t s);
      logic [2:0] stg;
      stg = STG_NONE;
      case (s)
         PRED:    stg = STG_PRED;
         NEW:     stg = STG_NEWLM;
         UPD:     stg = STG_UPD;
         default: stg = STG_NONE;
      endcase
      return stg;
   endfunction

endpackage

// File: rtl/ekf_stage_seq_watchdog.sv
// Per-stage watchdog: counts cycles while a stage is active and flags
// expiry on the TIMEOUT-th active cycle.
module stage_watchdog #(
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TO_W-1:0] cnt;

   // Cycle counter, restarted whenever no stage is active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = enable && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/ekf_stage_seq.sv
// EKF-SLAM step sequencer: issues PREDICT, then one NEWLM or UPDATE stage
// per host observation, tracks the map landmark count and flags bad
// observations and stalled stages.
import ekf_pkg::*;

module ekf_stage_seq #(
   parameter int LM_W    = 10,
   parameter int MAX_LM  = 1023,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic            clk,
   input  logic            sys_rst,
   input  logic            step_val,
   output logic            step_rdy,
   input  logic            obs_val,
   output logic            obs_rdy,
   input  logic [LM_W-1:0] obs_lk,
   input  logic            obs_new,
   input  logic            obs_last,
   input  logic            lm_clear,
   output logic [2:0]      stage_val,
   input  logic [2:0]      stage_rdy,
   output logic [LM_W-1:0] landmark_num,
   output logic [LM_W-1:0] l_k,
   output logic            busy,
   output logic            err_inval,
   output logic            err_full,
   output logic            err_timeout
);

   localparam logic [LM_W-1:0] MAX_LM_V = LM_W'(MAX_LM);

   state_t          state;
   state_t          state_nxt;
   logic [LM_W-1:0] lk_q;
   logic            new_q;
   logic            last_q;
   logic            wd_expired;
   logic            rdy_hit;
   logic            chk_upd;
   logic            chk_new;
   logic            step_acc;

   // Only the stage_rdy bit matching the active stage counts as completion.
   assign rdy_hit  = |(stage_rdy & stage_val);
   assign chk_upd  = !new_q && (lk_q < landmark_num);
   assign chk_new  = new_q && (landmark_num < MAX_LM_V);
   assign step_acc = step_val && step_rdy;

   stage_watchdog #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (sys_rst),
      .clear   (stage_val == STG_NONE),
      .enable  (stage_val != STG_NONE),
      .expired (wd_expired)
   );

   // State register.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic; a completion pulse beats a same-cycle watchdog expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (step_val && !lm_clear) state_nxt = PRED;
         PRED:  if (stage_rdy[0])          state_nxt = OBS;
                else if (wd_expired)       state_nxt = IDLE;
         OBS:   if (obs_val)               state_nxt = CHECK;
                else if (step_val)         state_nxt = IDLE;
         CHECK: if (chk_upd)               state_nxt = UPD;
                else if (chk_new)          state_nxt = NEW;
                else                       state_nxt = last_q ? IDLE : OBS;
         NEW:   if (stage_rdy[1])          state_nxt = last_q ? IDLE : OBS;
                else if (wd_expired)       state_nxt = IDLE;
         UPD:   if (stage_rdy[2])          state_nxt = last_q ? IDLE : OBS;
                else if (wd_expired)       state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs; lm_clear holds off a same-cycle step.
   always_comb begin
      step_rdy = (state == IDLE) && !lm_clear;
      obs_rdy  = (state == OBS);
      busy     = (state != IDLE);
   end

   // Registered stage code, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) stage_val <= STG_NONE;
      else         stage_val <= stage_of(state_nxt);
   end

   // Captured observation fields, consumed in CHECK and at stage completion.
   always_ff @(posedge clk) begin
      if (state == OBS && obs_val) begin
         lk_q   <= obs_lk;
         new_q  <= obs_new;
         last_q <= obs_last;
      end
   end

   // Landmark count, active index and sticky error flags.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         landmark_num <= '0;
         l_k          <= '0;
         err_inval    <= 1'b0;
         err_full     <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         if (state == IDLE && lm_clear) begin
            landmark_num <= '0;
         end else if (state == NEW && stage_rdy[1] && landmark_num != MAX_LM_V) begin
            landmark_num <= landmark_num + 1'b1;
         end

         if (state == CHECK) begin
            if (chk_upd)      l_k <= lk_q;
            else if (chk_new) l_k <= landmark_num;
         end

         if (step_acc) begin
            err_inval   <= 1'b0;
            err_full    <= 1'b0;
            err_timeout <= 1'b0;
         end else begin
            if (state == CHECK && !new_q && !chk_upd) err_inval   <= 1'b1;
            if (state == CHECK && new_q && !chk_new)  err_full    <= 1'b1;
            if (wd_expired && !rdy_hit)               err_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ekf_stage_seq.sv
// Directed bench for ekf_stage_seq with MAX_LM=4 and TIMEOUT=20.
module tb_ekf_stage_seq;

   logic       clk;
   logic       sys_rst;
   logic       step_val;
   logic       step_rdy;
   logic       obs_val;
   logic       obs_rdy;
   logic [9:0] obs_lk;
   logic       obs_new;
   logic       obs_last;
   logic       lm_clear;
   logic [2:0] stage_val;
   logic [2:0] stage_rdy;
   logic [9:0] landmark_num;
   logic [9:0] l_k;
   logic       busy;
   logic       err_inval;
   logic       err_full;
   logic       err_timeout;

   int n_vec;
   int n_err;

   ekf_stage_seq #(
      .LM_W    (10),
      .MAX_LM  (4),
      .TO_W    (16),
      .TIMEOUT (20)
   ) dut (
      .clk          (clk),
      .sys_rst      (sys_rst),
      .step_val     (step_val),
      .step_rdy     (step_rdy),
      .obs_val      (obs_val),
      .obs_rdy      (obs_rdy),
      .obs_lk       (obs_lk),
      .obs_new      (obs_new),
      .obs_last     (obs_last),
      .lm_clear     (lm_clear),
      .stage_val    (stage_val),
      .stage_rdy    (stage_rdy),
      .landmark_num (landmark_num),
      .l_k          (l_k),
      .busy         (busy),
      .err_inval    (err_inval),
      .err_full     (err_full),
      .err_timeout  (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Start a step, hold PREDICT for wait_cyc cycles, then complete it.
   task automatic step_pred(input int wait_cyc);
      step_val = 1'b1;
      tick();
      step_val = 1'b0;
      chk("pred_stage", 32'(stage_val), 32'h1);
      chk("pred_busy", 32'(busy), 32'h1);
      repeat (wait_cyc - 1) tick();
      chk("pred_held", 32'(stage_val), 32'h1);
      stage_rdy = 3'b001;
      tick();
      stage_rdy = 3'b000;
      chk("obs_rdy_up", 32'(obs_rdy), 32'h1);
      chk("pred_dropped", 32'(stage_val), 32'h0);
   endtask

   // Present one observation; returns after the CHECK cycle has resolved.
   task automatic do_obs(input logic nw, input logic [9:0] lk, input logic last);
      obs_val  = 1'b1;
      obs_new  = nw;
      obs_lk   = lk;
      obs_last = last;
      tick();
      obs_val = 1'b0;
      chk("check_obs_rdy", 32'(obs_rdy), 32'h0);
      tick();
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      sys_rst   = 1'b1;
      step_val  = 1'b0;
      obs_val   = 1'b0;
      obs_lk    = '0;
      obs_new   = 1'b0;
      obs_last  = 1'b0;
      lm_clear  = 1'b0;
      stage_rdy = 3'b000;

      // Reset values
      repeat (2) tick();
      chk("rst_step_rdy", 32'(step_rdy), 32'h1);
      chk("rst_stage", 32'(stage_val), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_lm", 32'(landmark_num), 32'h0);
      chk("rst_lk", 32'(l_k), 32'h0);
      chk("rst_errs", {29'h0, err_inval, err_full, err_timeout}, 32'h0);
      sys_rst = 1'b0;
      tick();

      // Three new landmarks from an empty map
      step_pred(3);
      for (int i = 0; i < 3; i++) begin
         do_obs(1'b1, 10'd0, (i == 2));
         chk("new_stage", 32'(stage_val), 32'h2);
         chk("new_lk", 32'(l_k), 32'(i));
         stage_rdy = 3'b010;
         tick();
         stage_rdy = 3'b000;
         chk("new_count", 32'(landmark_num), 32'(i + 1));
      end
      chk("new_idle", 32'(step_rdy), 32'h1);
      chk("new_errs", {29'h0, err_inval, err_full, err_timeout}, 32'h0);

      // Known observation lk=0, PREDICT completes after 10 cycles
      step_pred(10);
      do_obs(1'b0, 10'd0, 1'b1);
      chk("upd_stage", 32'(stage_val), 32'h4);
      chk("upd_lk", 32'(l_k), 32'h0);
      stage_rdy = 3'b100;
      tick();
      stage_rdy = 3'b000;
      chk("upd_idle", 32'(step_rdy), 32'h1);
      chk("upd_done", 32'(stage_val), 32'h0);

      // Out-of-range known index
      step_pred(2);
      do_obs(1'b0, 10'd5, 1'b1);
      chk("inval_stage", 32'(stage_val), 32'h0);
      chk("inval_err", 32'(err_inval), 32'h1);
      chk("inval_idle", 32'(busy), 32'h0);
      step_val = 1'b1;
      tick();
      step_val = 1'b0;
      chk("inval_cleared", 32'(err_inval), 32'h0);
      chk("inval_next_pred", 32'(stage_val), 32'h1);
      stage_rdy = 3'b001;
      tick();
      stage_rdy = 3'b000;

      // Zero-observation step ends on a step_val pulse in OBS
      step_val = 1'b1;
      tick();
      step_val = 1'b0;
      chk("zero_obs_idle", 32'(busy), 32'h0);
      tick();
      chk("zero_obs_no_restart", 32'(stage_val), 32'h0);

      // Fill the map, then overflow it
      step_pred(2);
      do_obs(1'b1, 10'd0, 1'b1);
      chk("fill_lk", 32'(l_k), 32'h3);
      stage_rdy = 3'b010;
      tick();
      stage_rdy = 3'b000;
      chk("fill_count", 32'(landmark_num), 32'h4);
      step_pred(2);
      do_obs(1'b1, 10'd0, 1'b1);
      chk("full_no_newlm", 32'(stage_val), 32'h0);
      chk("full_err", 32'(err_full), 32'h1);
      chk("full_count", 32'(landmark_num), 32'h4);
      chk("full_idle", 32'(busy), 32'h0);

      // PREDICT never completes; stray UPDATE completion ignored
      step_val = 1'b1;
      tick();
      step_val = 1'b0;
      chk("to_err_full_cleared", 32'(err_full), 32'h0);
      for (int i = 1; i < 20; i++) begin
         if (i == 5) stage_rdy = 3'b100;
         tick();
         stage_rdy = 3'b000;
      end
      chk("to_still_pred", 32'(stage_val), 32'h1);
      chk("to_not_yet", 32'(err_timeout), 32'h0);
      tick();
      chk("to_stage_drop", 32'(stage_val), 32'h0);
      chk("to_err", 32'(err_timeout), 32'h1);
      chk("to_idle", 32'(busy), 32'h0);
      chk("to_count", 32'(landmark_num), 32'h4);

      // Asynchronous reset during UPDATE
      step_pred(2);
      do_obs(1'b0, 10'd1, 1'b1);
      chk("rupd_stage", 32'(stage_val), 32'h4);
      chk("rupd_lk", 32'(l_k), 32'h1);
      #2;
      sys_rst = 1'b1;
      #1;
      chk("arst_stage", 32'(stage_val), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_count", 32'(landmark_num), 32'h0);
      tick();
      sys_rst = 1'b0;
      tick();
      chk("arst_step_rdy", 32'(step_rdy), 32'h1);

      // lm_clear ignored during NEW, honoured in IDLE over step_val
      step_pred(2);
      do_obs(1'b1, 10'd0, 1'b1);
      chk("clr_new_stage", 32'(stage_val), 32'h2);
      lm_clear  = 1'b1;
      stage_rdy = 3'b010;
      tick();
      stage_rdy = 3'b000;
      lm_clear  = 1'b0;
      chk("clr_in_new_ignored", 32'(landmark_num), 32'h1);
      lm_clear = 1'b1;
      step_val = 1'b1;
      tick();
      lm_clear = 1'b0;
      step_val = 1'b0;
      chk("clr_idle_count", 32'(landmark_num), 32'h0);
      chk("clr_beats_step", 32'(busy), 32'h0);
      chk("clr_no_stage", 32'(stage_val), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
